// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if
//   Bundle of requester, shared-multiplier and response signals for
//   mult_share_arbiter.
//   Ports of the bundle:
//     req_valid/req_a/req_b  requester operand pairs (4 bits per requester)
//     req_ready              one-hot accept back to requesters
//     mul_a/mul_b/mul_p      operand and product connection to the multiplier
//     rsp_valid/rsp_ready    response handshake
//     rsp_p/rsp_id           product and owning requester index
//     busy                   arbiter is not idle
//   Modports: slave = arbiter side, master = requester/multiplier/consumer side.
interface mult_share_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [4*NREQ-1:0] req_a;
   logic [4*NREQ-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic [3:0]        mul_a;
   logic [3:0]        mul_b;
   logic [7:0]        mul_p;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [7:0]        rsp_p;
   logic [IDW-1:0]    rsp_id;
   logic              busy;

   modport slave (
      input  req_valid, req_a, req_b, mul_p, rsp_ready,
      output req_ready, mul_a, mul_b, rsp_valid, rsp_p, rsp_id, busy
   );

   modport master (
      output req_valid, req_a, req_b, mul_p, rsp_ready,
      input  req_ready, mul_a, mul_b, rsp_valid, rsp_p, rsp_id, busy
   );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one combinational 4x4 unsigned multiplier among NREQ requesters.
//   A winner is picked while idle, its operands are registered onto mul_a/mul_b,
//   the product is captured SETTLE cycles later and presented with the
//   requester index until the consumer takes it.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    mult_share_arbiter_if.slave (requests, multiplier link, response)
//   Configuration:
//     MULT_ARB_ROUND_ROBIN_EN defined   -> round-robin arbitration
//     MULT_ARB_ROUND_ROBIN_EN undefined -> fixed priority, lowest index wins
//
//   state  | meaning
//   IDLE   | waiting for any req_valid, grant presented on req_ready
//   WAIT   | operands held on the multiplier, counting settle cycles
//   RESP   | product held on rsp_p/rsp_id until rsp_ready
module mult_share_arbiter #(
   parameter int NREQ   = 4,
   parameter int SETTLE = 1,
   parameter int IDW    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mult_share_arbiter_if.slave   bus
);
   localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [3:0]     mul_a_q, mul_a_d;
   logic [3:0]     mul_b_q, mul_b_d;
   logic [7:0]     rsp_p_q, rsp_p_d;
   logic [IDW-1:0] rsp_id_q, rsp_id_d;

   logic           any_req;
   logic [IDW-1:0] gnt_idx;
   logic           accept;

   assign accept = (state_q == S_IDLE) && any_req;

`ifdef MULT_ARB_ROUND_ROBIN_EN
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

   // Scan from the far end back toward rr_ptr so the first requester at or
   // after rr_ptr is the last one written, i.e. the winner.
   always_comb begin
      int idx;
      idx     = 0;
      gnt_idx = '0;
      any_req = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % NREQ;
         if (bus.req_valid[idx]) begin
            gnt_idx = IDW'(idx);
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_ptr_q <= '0;
      else        rr_ptr_q <= rr_ptr_d;
   end
`else
   always_comb begin
      gnt_idx = '0;
      any_req = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i]) begin
            gnt_idx = IDW'(i);
            any_req = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mul_a_d  = mul_a_q;
      mul_b_d  = mul_b_q;
      rsp_p_d  = rsp_p_q;
      rsp_id_d = rsp_id_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               mul_a_d  = bus.req_a[4*int'(gnt_idx) +: 4];
               mul_b_d  = bus.req_b[4*int'(gnt_idx) +: 4];
               rsp_id_d = gnt_idx;
               cnt_d    = CW'(SETTLE);
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               rsp_p_d = bus.mul_p;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         rsp_p_q  <= '0;
         rsp_id_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         rsp_p_q  <= rsp_p_d;
         rsp_id_q <= rsp_id_d;
      end
   end

   assign bus.req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_p     = rsp_p_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
//   Drives two arbiters (SETTLE=1 and SETTLE=3) from the same requester inputs,
//   each with its own behavioural multiplier, and compares against a
//   transaction-level model of arbitration, product and latency.
//   Honours MULT_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mult_share_arbiter;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;
   localparam int W     = 4 * NREQ;
   localparam int SET_A = 1;
   localparam int SET_B = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NREQ-1:0] req_valid;
   logic [W-1:0]    req_a;
   logic [W-1:0]    req_b;
   logic            rsp_ready;

   int checks = 0;
   int errors = 0;
   int rr_ptr = 0;

   mult_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus_a ();
   mult_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus_b ();

   assign bus_a.req_valid = req_valid;
   assign bus_a.req_a     = req_a;
   assign bus_a.req_b     = req_b;
   assign bus_a.rsp_ready = rsp_ready;
   assign bus_a.mul_p     = 8'(bus_a.mul_a) * 8'(bus_a.mul_b);
   assign bus_b.req_valid = req_valid;
   assign bus_b.req_a     = req_a;
   assign bus_b.req_b     = req_b;
   assign bus_b.rsp_ready = rsp_ready;
   assign bus_b.mul_p     = 8'(bus_b.mul_a) * 8'(bus_b.mul_b);

   mult_share_arbiter #(.NREQ(NREQ), .SETTLE(SET_A), .IDW(IDW)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a));
   mult_share_arbiter #(.NREQ(NREQ), .SETTLE(SET_B), .IDW(IDW)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant(input logic [NREQ-1:0] v);
`ifdef MULT_ARB_ROUND_ROBIN_EN
      for (int k = 0; k < NREQ; k++)
         if (v[(rr_ptr + k) % NREQ]) return (rr_ptr + k) % NREQ;
`else
      for (int i = 0; i < NREQ; i++)
         if (v[i]) return i;
`endif
      return -1;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_mul_a"},     bus_a.mul_a, 0);
      check({tag, "_mul_b"},     bus_a.mul_b, 0);
      check({tag, "_rsp_p"},     bus_a.rsp_p, 0);
      check({tag, "_rsp_id"},    bus_a.rsp_id, 0);
      check({tag, "_rsp_valid"}, bus_a.rsp_valid, 0);
      check({tag, "_busy"},      bus_a.busy, 0);
      check({tag, "_req_ready"}, bus_a.req_ready, 0);
      check({tag, "_b_valid"},   bus_b.rsp_valid, 0);
   endtask

   task automatic do_reset();
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      rst_n     = 1'b0;
      rr_ptr    = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One operation on dut_a; call with dut_a idle, away from a clock edge.
   task automatic op(input logic [NREQ-1:0] v, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int hold);
      int g;
      int n;
      logic [3:0] ea, eb;
      logic [7:0] ep;
      req_valid = v;
      req_a     = a;
      req_b     = b;
      rsp_ready = 1'($urandom);
      #1;
      g = model_grant(v);
      if (g < 0) begin
         check("noreq_ready", bus_a.req_ready, 0);
         @(posedge clk);
         #1;
         check("noreq_busy", bus_a.busy, 0);
         return;
      end
      ea = a[4*g +: 4];
      eb = b[4*g +: 4];
      ep = ea * eb;
      check("grant", bus_a.req_ready, 1 << g);
      @(posedge clk);
      rr_ptr = (g + 1) % NREQ;
      #1;
      req_a     = W'($urandom);
      req_b     = W'($urandom);
      check("accept_ready", bus_a.req_ready, 0);
      check("accept_busy", bus_a.busy, 1);
      n = 0;
      while (bus_a.rsp_valid !== 1'b1 && n < 20) begin
         check("wait_mul_a", bus_a.mul_a, ea);
         check("wait_mul_b", bus_a.mul_b, eb);
         rsp_ready = 1'($urandom);
         req_a     = W'($urandom);
         @(posedge clk);
         n++;
         #1;
      end
      rsp_ready = 1'b0;
      check("latency", n, SET_A);
      check("rsp_p", bus_a.rsp_p, ep);
      check("rsp_id", bus_a.rsp_id, g);
      check("rsp_busy", bus_a.busy, 1);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid", bus_a.rsp_valid, 1);
         check("hold_p", bus_a.rsp_p, ep);
         check("hold_id", bus_a.rsp_id, g);
         check("hold_ready", bus_a.req_ready, 0);
         check("hold_busy", bus_a.busy, 1);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      req_valid = '0;
      check("done_valid", bus_a.rsp_valid, 0);
      check("done_busy", bus_a.busy, 0);
      check("idle_mul_a", bus_a.mul_a, ea);
      check("idle_mul_b", bus_a.mul_b, eb);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      rst_n     = 1'b0;
      #2;
      check_all_zero("reset");
      do_reset();

      // Requester 3, 15*15 on both arbiters; latency 1 vs 3.
      req_valid = 4'b1000;
      req_a     = 16'hF000;
      req_b     = 16'hF000;
      #1;
      check("t2_grant_a", bus_a.req_ready, 4'b1000);
      check("t2_grant_b", bus_b.req_ready, 4'b1000);
      @(posedge clk);
      rr_ptr = 0;
      #1 req_valid = '0;
      n = 0;
      while (bus_b.rsp_valid !== 1'b1 && n < 20) begin
         @(posedge clk);
         n++;
         #1;
      end
      check("t2_latency_b", n, SET_B);
      check("t2_rsp_p_b", bus_b.rsp_p, 225);
      check("t2_rsp_id_b", bus_b.rsp_id, 3);
      check("t2_rsp_p_a", bus_a.rsp_p, 225);
      check("t2_valid_a", bus_a.rsp_valid, 1);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      check("t2_done_b", bus_b.rsp_valid, 0);

      // 3*5 from requester 0.
      op(4'b0001, 16'h0003, 16'h0005, 1);

      // All requesters held: grant order from the model.
      do_reset();
      repeat (5) op(4'b1111, W'($urandom), W'($urandom), 0);

      // Long stall in RESP.
      op(4'b0110, W'($urandom), W'($urandom), 5);

      // Request withdrawn before any edge.
      req_valid = 4'b1010;
      #2 req_valid = '0;
      @(posedge clk);
      #1;
      check("drop_busy", bus_a.busy, 0);
      check("drop_valid", bus_a.rsp_valid, 0);

      // Reset during WAIT of the slow arbiter and the fast one.
      req_valid = 4'b0001;
      req_a     = 16'h0009;
      req_b     = 16'h0009;
      @(posedge clk);
      #1 req_valid = '0;
      #2 rst_n = 1'b0;
      rr_ptr = 0;
      #1;
      check_all_zero("midrst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         check("postrst_valid_a", bus_a.rsp_valid, 0);
         check("postrst_valid_b", bus_b.rsp_valid, 0);
      end
      op(4'b0100, 16'h0200, 16'h0700, 2);

      repeat (30) op(NREQ'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                     int'($urandom_range(0, 3)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
